// File: rtl/lamp_fpu_log_norm_if.sv
// Shared bfloat16 constants and the valid/ready bus for the ln() normalize/round back end.
package lampFPU_pkg;

  localparam int unsigned LAMP_FLOAT_E_DW   = 8;
  localparam int unsigned LAMP_FLOAT_F_DW   = 7;
  localparam int unsigned LAMP_FLOAT_E_BIAS = 127;

  // Pre-resolved special result carried down the pipe alongside the data path
  typedef struct packed {
    logic                       is_special;
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW-1:0] f;
    logic                       invalid;
    logic                       div_zero;
  } log_special_t;

endpackage

interface lamp_fpu_log_norm_if #(
  parameter int unsigned INT_DW  = 8,
  parameter int unsigned FRAC_DW = 11
);
  logic                                      valid_i;
  logic                                      ready_o;
  logic                                      s_res_i;
  logic [INT_DW+FRAC_DW-1:0]                 mag_i;
  logic                                      s_op_i;
  logic                                      isZ_op_i;
  logic                                      isInf_op_i;
  logic                                      isSNAN_op_i;
  logic                                      isQNAN_op_i;
  logic                                      ready_i;
  logic                                      valid_o;
  logic                                      s_res_o;
  logic [lampFPU_pkg::LAMP_FLOAT_E_DW-1:0]   e_res_o;
  logic [lampFPU_pkg::LAMP_FLOAT_F_DW-1:0]   f_res_o;
  logic                                      isInvalid_o;
  logic                                      isDivByZero_o;
  logic                                      isInexact_o;

  modport slave (
    input  valid_i, s_res_i, mag_i, s_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i, ready_i,
    output ready_o, valid_o, s_res_o, e_res_o, f_res_o, isInvalid_o, isDivByZero_o, isInexact_o
  );

  modport master (
    output valid_i, s_res_i, mag_i, s_op_i, isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i, ready_i,
    input  ready_o, valid_o, s_res_o, e_res_o, f_res_o, isInvalid_o, isDivByZero_o, isInexact_o
  );
endinterface

// File: rtl/lamp_fpu_log_norm.sv
// Normalize |ln(x)| (Qi.f fixed point) to bfloat16 with RNE rounding and special-case resolution.
// Stall-all pipeline: input register, classify/encode, normalize, round into the output register.
module lamp_fpu_log_norm
  import lampFPU_pkg::*;
#(
  parameter int unsigned INT_DW  = 8,
  parameter int unsigned FRAC_DW = 11
) (
  input logic                 clk,
  input logic                 rst,
  lamp_fpu_log_norm_if.slave  bus
);

  localparam int unsigned MAG_DW = INT_DW + FRAC_DW;
  localparam int unsigned P_W    = $clog2(MAG_DW);
  localparam int unsigned E_DW   = LAMP_FLOAT_E_DW;
  localparam int unsigned F_DW   = LAMP_FLOAT_F_DW;
  localparam int unsigned E_OFF  = LAMP_FLOAT_E_BIAS - FRAC_DW;
  localparam int unsigned LOW_DW = MAG_DW - F_DW - 2;
  localparam logic [F_DW-1:0] QNAN_F = {1'b1, {(F_DW-1){1'b0}}};

  logic advance;
  assign advance     = ~bus.valid_o | bus.ready_i;
  assign bus.ready_o = advance;

  // Input register
  logic              v0, s_res0, s_op0, z0, inf0, snan0, qnan0;
  logic [MAG_DW-1:0] mag0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v0 <= 1'b0; s_res0 <= 1'b0; s_op0 <= 1'b0; z0 <= 1'b0;
      inf0 <= 1'b0; snan0 <= 1'b0; qnan0 <= 1'b0; mag0 <= '0;
    end else if (advance) begin
      v0     <= bus.valid_i;
      s_res0 <= bus.s_res_i;
      s_op0  <= bus.s_op_i;
      z0     <= bus.isZ_op_i;
      inf0   <= bus.isInf_op_i;
      snan0  <= bus.isSNAN_op_i;
      qnan0  <= bus.isQNAN_op_i;
      mag0   <= bus.mag_i;
    end
  end

  // Special-case priority and leading-one position
  log_special_t   spec_c;
  logic [P_W-1:0] p_c;

  always_comb begin
    spec_c = '0;
    if (snan0) begin
      spec_c.is_special = 1'b1; spec_c.e = '1; spec_c.f = QNAN_F; spec_c.invalid = 1'b1;
    end else if (qnan0) begin
      spec_c.is_special = 1'b1; spec_c.e = '1; spec_c.f = QNAN_F;
    end else if (z0) begin
      spec_c.is_special = 1'b1; spec_c.s = 1'b1; spec_c.e = '1; spec_c.div_zero = 1'b1;
    end else if (s_op0) begin
      spec_c.is_special = 1'b1; spec_c.e = '1; spec_c.f = QNAN_F; spec_c.invalid = 1'b1;
    end else if (inf0) begin
      spec_c.is_special = 1'b1; spec_c.e = '1;
    end else if (mag0 == '0) begin
      spec_c.is_special = 1'b1;
    end
  end

  always_comb begin
    p_c = '0;
    for (int unsigned i = 0; i < MAG_DW; i++) begin
      if (mag0[i]) p_c = P_W'(i);
    end
  end

  logic              v1, s_res1;
  log_special_t      spec1;
  logic [P_W-1:0]    p1;
  logic [MAG_DW-1:0] mag1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0; s_res1 <= 1'b0; spec1 <= '0; p1 <= '0; mag1 <= '0;
    end else if (advance) begin
      v1     <= v0;
      s_res1 <= s_res0;
      spec1  <= spec_c;
      p1     <= p_c;
      mag1   <= mag0;
    end
  end

  // Normalize: the leading one is shifted out of the top, leaving fraction/guard/sticky
  logic [P_W-1:0]    shamt;
  logic [MAG_DW-2:0] norm;
  logic [F_DW-1:0]   frac_c;
  logic              guard_c, sticky_c;
  logic [E_DW-1:0]   e_c;

  always_comb begin
    shamt    = P_W'(MAG_DW - 1) - p1;
    norm     = (MAG_DW-1)'(mag1 << shamt);
    frac_c   = norm[MAG_DW-2 -: F_DW];
    guard_c  = norm[LOW_DW];
    sticky_c = |norm[LOW_DW-1:0];
    e_c      = E_DW'(p1) + E_DW'(E_OFF);
  end

  logic            v2, s_res2, g2, st2;
  log_special_t    spec2;
  logic [E_DW-1:0] e2;
  logic [F_DW-1:0] frac2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v2 <= 1'b0; s_res2 <= 1'b0; g2 <= 1'b0; st2 <= 1'b0;
      spec2 <= '0; e2 <= '0; frac2 <= '0;
    end else if (advance) begin
      v2     <= v1;
      s_res2 <= s_res1;
      g2     <= guard_c;
      st2    <= sticky_c;
      spec2  <= spec1;
      e2     <= e_c;
      frac2  <= frac_c;
    end
  end

  // Round to nearest even; a fraction carry-out bumps the exponent
  logic            rnd;
  logic [F_DW:0]   sum;
  logic [E_DW-1:0] e_rnd;
  logic [F_DW-1:0] f_rnd;

  always_comb begin
    rnd   = g2 & (st2 | frac2[0]);
    sum   = {1'b0, frac2} + {{F_DW{1'b0}}, rnd};
    f_rnd = sum[F_DW-1:0];
    e_rnd = sum[F_DW] ? e2 + E_DW'(1) : e2;
  end

  // Output register; a bubble clears every output so flags read zero when invalid
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.valid_o <= 1'b0; bus.s_res_o <= 1'b0; bus.e_res_o <= '0; bus.f_res_o <= '0;
      bus.isInvalid_o <= 1'b0; bus.isDivByZero_o <= 1'b0; bus.isInexact_o <= 1'b0;
    end else if (advance) begin
      bus.valid_o <= v2;
      if (!v2) begin
        bus.s_res_o <= 1'b0; bus.e_res_o <= '0; bus.f_res_o <= '0;
        bus.isInvalid_o <= 1'b0; bus.isDivByZero_o <= 1'b0; bus.isInexact_o <= 1'b0;
      end else if (spec2.is_special) begin
        bus.s_res_o       <= spec2.s;
        bus.e_res_o       <= spec2.e;
        bus.f_res_o       <= spec2.f;
        bus.isInvalid_o   <= spec2.invalid;
        bus.isDivByZero_o <= spec2.div_zero;
        bus.isInexact_o   <= 1'b0;
      end else begin
        bus.s_res_o       <= s_res2;
        bus.e_res_o       <= e_rnd;
        bus.f_res_o       <= f_rnd;
        bus.isInvalid_o   <= 1'b0;
        bus.isDivByZero_o <= 1'b0;
        bus.isInexact_o   <= g2 | st2;
      end
    end
  end

endmodule

// File: tb/tb_lamp_fpu_log_norm.sv
// Bench for lamp_fpu_log_norm: vector table, random traffic with backpressure, stall and reset sequences.
module tb_lamp_fpu_log_norm;
  import lampFPU_pkg::*;

  typedef struct {
    logic        s_res;
    logic [18:0] mag;
    logic        s_op, z, inf, snan, qnan;
  } in_t;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] f;
    logic       inv, dz, inx;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lamp_fpu_log_norm_if bus ();
  lamp_fpu_log_norm dut (.clk(clk), .rst(rst), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  vec_t sb[$];
  vec_t tbl[$];
  vec_t cur;
  logic done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic out_t get_out();
    return {bus.s_res_o, bus.e_res_o, bus.f_res_o, bus.isInvalid_o, bus.isDivByZero_o, bus.isInexact_o};
  endfunction

  // Reference: arithmetic rounding on the integer magnitude
  function automatic out_t model(input in_t v);
    out_t        o;
    int          p, e;
    int unsigned m, keep, rem, half;
    logic        rup;
    o = '0;
    if (v.snan) begin
      o.e = 8'hFF; o.f = 7'h40; o.inv = 1'b1;
    end else if (v.qnan) begin
      o.e = 8'hFF; o.f = 7'h40;
    end else if (v.z) begin
      o.s = 1'b1; o.e = 8'hFF; o.dz = 1'b1;
    end else if (v.s_op) begin
      o.e = 8'hFF; o.f = 7'h40; o.inv = 1'b1;
    end else if (v.inf) begin
      o.e = 8'hFF;
    end else if (v.mag != 19'd0) begin
      m = 32'(v.mag);
      p = $clog2(m + 1) - 1;
      rup = 1'b0;
      if (p >= 8) begin
        keep  = m >> (p - 7);
        rem   = m & ((32'd1 << (p - 7)) - 1);
        half  = 32'd1 << (p - 8);
        rup   = (rem > half) || ((rem == half) && keep[0]);
        o.inx = (rem != 0);
      end else begin
        keep = m << (7 - p);
      end
      keep = keep + 32'(rup);
      e = p + 116;
      if (keep == 256) begin
        keep = 128;
        e++;
      end
      o.s = v.s_res;
      o.e = 8'(e);
      o.f = keep[6:0];
    end
    return o;
  endfunction

  task automatic add(input string nm, input logic sr, input logic [18:0] mag, input logic sop,
                     input logic z, input logic inf, input logic sn, input logic qn,
                     input logic es, input logic [7:0] ee, input logic [6:0] ef,
                     input logic einv, input logic edz, input logic einx);
    vec_t v;
    v.name = nm;
    v.in.s_res = sr; v.in.mag = mag; v.in.s_op = sop; v.in.z = z;
    v.in.inf = inf; v.in.snan = sn; v.in.qnan = qn;
    v.exp = {es, ee, ef, einv, edz, einx};
    tbl.push_back(v);
  endtask

  function automatic vec_t rnd_vec(input string nm);
    vec_t v;
    v.name     = nm;
    v.in.s_res = 1'($urandom);
    v.in.mag   = 19'($urandom);
    v.in.s_op  = ($urandom_range(0, 7) == 0);
    v.in.z     = ($urandom_range(0, 9) == 0);
    v.in.inf   = ($urandom_range(0, 9) == 0);
    v.in.snan  = ($urandom_range(0, 15) == 0);
    v.in.qnan  = ($urandom_range(0, 15) == 0);
    v.exp      = model(v.in);
    return v;
  endfunction

  task automatic send(input vec_t v);
    int n;
    cur = v;
    bus.s_res_i = v.in.s_res; bus.mag_i = v.in.mag; bus.s_op_i = v.in.s_op;
    bus.isZ_op_i = v.in.z; bus.isInf_op_i = v.in.inf;
    bus.isSNAN_op_i = v.in.snan; bus.isQNAN_op_i = v.in.qnan;
    bus.valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_o) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout %s: got ready_o=0 for 200 cycles required 1", v.name);
        break;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check({"drain_", nm}, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: push on acceptance, pop on delivery, flush on reset
  always @(negedge clk) begin
    vec_t x;
    if (!rst) begin
      sb.delete();
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got beat %0h required none", get_out());
        end else begin
          x = sb.pop_front();
          check(x.name, 32'(get_out()), 32'(x.exp));
        end
      end else if (!bus.valid_o) begin
        check("idle_zero", 32'(get_out()), 32'd0);
      end
      if (bus.valid_i && bus.ready_o) sb.push_back(cur);
    end
  end

  initial begin
    vec_t sv[5];
    out_t snap;
    int   n, seen;

    bus.valid_i = 1'b0; bus.s_res_i = 1'b0; bus.mag_i = '0; bus.s_op_i = 1'b0;
    bus.isZ_op_i = 1'b0; bus.isInf_op_i = 1'b0; bus.isSNAN_op_i = 1'b0; bus.isQNAN_op_i = 1'b0;
    bus.ready_i = 1'b1;
    done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.valid_o, get_out()}, 32'd0);
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    //   name          sr  mag       sop z  inf sn qn   s  e      f      inv dz inx
    add("one",         0, 19'h00800, 0, 0, 0, 0, 0,   0, 8'd127, 7'h00, 0, 0, 0);
    add("round_down",  1, 19'h0058B, 0, 0, 0, 0, 0,   1, 8'd126, 7'h31, 0, 0, 1);
    add("carry",       0, 19'h7FFFF, 0, 0, 0, 0, 0,   0, 8'd135, 7'h00, 0, 0, 1);
    add("tie_even_dn", 0, 19'h40400, 0, 0, 0, 0, 0,   0, 8'd134, 7'h00, 0, 0, 1);
    add("tie_even_up", 0, 19'h40C00, 0, 0, 0, 0, 0,   0, 8'd134, 7'h02, 0, 0, 1);
    add("zero_op",     1, 19'h01234, 0, 1, 0, 0, 0,   1, 8'hFF,  7'h00, 0, 1, 0);
    add("neg_zero_op", 0, 19'h00000, 1, 1, 0, 0, 0,   1, 8'hFF,  7'h00, 0, 1, 0);
    add("neg_op",      1, 19'h00100, 1, 0, 0, 0, 0,   0, 8'hFF,  7'h40, 1, 0, 0);
    add("snan",        1, 19'h00800, 1, 1, 1, 1, 1,   0, 8'hFF,  7'h40, 1, 0, 0);
    add("qnan_over_z", 1, 19'h00800, 0, 1, 0, 0, 1,   0, 8'hFF,  7'h40, 0, 0, 0);
    add("inf",         1, 19'h00800, 0, 0, 1, 0, 0,   0, 8'hFF,  7'h00, 0, 0, 0);
    add("neg_inf",     0, 19'h00800, 1, 0, 1, 0, 0,   0, 8'hFF,  7'h40, 1, 0, 0);
    add("mag_zero",    1, 19'h00000, 0, 0, 0, 0, 0,   0, 8'h00,  7'h00, 0, 0, 0);
    add("min_mag",     1, 19'h00001, 0, 0, 0, 0, 0,   1, 8'd116, 7'h00, 0, 0, 0);
    add("p1_pad",      0, 19'h00003, 0, 0, 0, 0, 0,   0, 8'd117, 7'h40, 0, 0, 0);
    add("p7_exact",    0, 19'h000FF, 0, 0, 0, 0, 0,   0, 8'd123, 7'h7F, 0, 0, 0);
    add("p8_carry",    0, 19'h001FF, 0, 0, 0, 0, 0,   0, 8'd125, 7'h00, 0, 0, 1);

    // Latency: first beat appears exactly three edges after acceptance
    send(tbl[0]);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("latency_edge%0d", k), 32'(bus.valid_o), (k == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i < tbl.size(); i++) send(tbl[i]);
    wait_drain("table");

    // Backpressure: 4-cycle stall once the first of 5 beats reaches the output
    for (int k = 0; k < 5; k++) begin
      sv[k] = rnd_vec($sformatf("stall_beat%0d", k));
      sv[k].in.z = 1'b0; sv[k].in.inf = 1'b0; sv[k].in.snan = 1'b0; sv[k].in.qnan = 1'b0;
      sv[k].in.s_op = 1'b0; sv[k].in.mag = sv[k].in.mag | 19'h00400;
      sv[k].exp = model(sv[k].in);
    end
    fork
      begin
        for (int k = 0; k < 5; k++) send(sv[k]);
      end
      begin
        n = 0;
        while (!bus.valid_o && n < 30) begin
          @(posedge clk); #1;
          n++;
        end
        bus.ready_i = 1'b0;
        snap = get_out();
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("stall_ready_o", 32'(bus.ready_o), 32'd0);
          check("stall_hold", {bus.valid_o, get_out()}, {1'b1, snap});
        end
        @(posedge clk); #1;
        bus.ready_i = 1'b1;
      end
    join
    wait_drain("stall");

    // Random traffic against random backpressure
    fork
      begin
        for (int k = 0; k < 40; k++) send(rnd_vec($sformatf("rand%0d", k)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.ready_i = 1'b1;
    wait_drain("random");

    // Reset mid-stall with three beats in flight
    for (int k = 0; k < 3; k++) send(tbl[1 + k]);
    bus.ready_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("stalled_before_reset", 32'(bus.valid_o), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_clear", {bus.valid_o, get_out()}, 32'd0);
    check("post_reset_ready", 32'(bus.ready_o), 32'd1);
    bus.ready_i = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (bus.valid_o) seen++;
    end
    check("no_stale_result", 32'(seen), 32'd0);

    // Recovery after reset
    send(tbl[1]);
    wait_drain("recovery");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lamp_fpu_log_norm.md
# lamp_fpu_log_norm

Normalize-and-round back end for the bfloat16 natural-log datapath. Consumes the unsigned fixed-point magnitude |ln(x)| and the result sign produced by the log core. Also consumes the original operand's sign and class flags. Converts the magnitude to a packed bfloat16 result with round-to-nearest-even, resolves special cases, and sets exception flags. It is a 3-stage stall-all pipeline with a valid/ready handshake on both sides.

## Interface
Parameters:
- INT_DW, 8, integer bits of the fixed-point magnitude.
- FRAC_DW, 11, fractional bits of the fixed-point magnitude; value = mag_i / 2^FRAC_DW.
- Exponent/fraction widths and bias come from lampFPU_pkg: LAMP_FLOAT_E_DW=8, LAMP_FLOAT_F_DW=7, LAMP_FLOAT_E_BIAS=127.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept; a beat is accepted when valid_i & ready_o.
- s_res_i  in  1  sign of ln(x) from the log core.
- mag_i  in  INT_DW+FRAC_DW  unsigned |ln(x)|, Q8.11.
- s_op_i  in  1  sign of the original operand x.
- isZ_op_i, isInf_op_i, isSNAN_op_i, isQNAN_op_i  in  1 each  operand class flags, aligned with mag_i.
- ready_i  in  1  downstream accepts.
- valid_o  out  1  result valid.
- s_res_o  out  1  result sign.
- e_res_o  out  LAMP_FLOAT_E_DW  biased result exponent.
- f_res_o  out  LAMP_FLOAT_F_DW  result fraction (hidden bit dropped).
- isInvalid_o  out  1  invalid operation.
- isDivByZero_o  out  1  ln(0).
- isInexact_o  out  1  rounding discarded nonzero bits.

## Operation
- Special-case priority:
  1. isSNAN → qNaN (s=0, e=0xFF, f=0x40), invalid=1.
  2. isQNAN → qNaN, invalid=0.
  3. isZ (either sign) → -Inf (s=1, e=0xFF, f=0), divByZero=1.
  4. s_op_i=1 → qNaN, invalid=1.
  5. isInf → +Inf (s=0, e=0xFF, f=0).
  6. mag_i=0 → +0 (s=0, e=0, f=0).
  7. Otherwise, normal path with s=s_res_i.
- Special cases ignore mag_i. Their inexact flag is 0.
- Normal path:
  - p = index of the leading one of mag_i (0..18).
  - Biased exponent e = p - FRAC_DW + LAMP_FLOAT_E_BIAS = p+116.
  - Output range is 116..135. No subnormal, overflow, or underflow is possible, so no such flags exist.
  - Fraction: the 7 bits below the leading one, zero-padded when p<7.
  - Guard: the next bit. Sticky: OR of all remaining bits.
  - RNE: round up iff guard & (sticky | lsb).
  - Fraction carry-out (0x7F+1) → f=0, e+1.
  - inexact = guard | sticky.
- Stage 1: register the inputs and classify the special case. Compute p with a priority encoder.
- Stage 2: left-shift the magnitude so the leading one sits at the MSB. Form e, the 7-bit fraction, guard, and sticky.
- Stage 3: round, fix up the carry, mux in the special result, and drive the output registers.

## Timing
- Latency: 3 cycles. A beat accepted at edge N is presented with valid_o=1 after edge N+3 when there is no stall.
- Advance: advance = ~valid_o | ready_i.
  - On advance, every stage and its valid bit shifts.
  - Otherwise, all stages hold.
  - ready_o = advance (combinational).
- Throughput is 1 beat per cycle. Bubbles propagate and are not collapsed.
- While valid_o & ~ready_i, all outputs stay stable and ready_o=0.
- valid_i is ignored when ready_o=0. Upstream holds the beat.
- Reset (rst=0 at a clock edge):
  - All stage valid bits and all outputs clear to 0.
  - ready_o=1 after reset.
  - In-flight beats are discarded, including when reset hits mid-stall.
- Flags are valid only while valid_o=1. They are zero when valid_o=0.

## Test plan
- Latency and exact value:
  - Stimulus: mag_i=0x00800 (1.0), s_res_i=0, ready_i=1, accepted at edge 0.
  - Required: valid_o=1 after edge 3; s=0, e=127, f=0x00, inexact=0.
- Round down:
  - Stimulus: mag_i=0x0058B, s_res_i=1.
  - Required: s=1, e=126, f=0x31, inexact=1.
- Carry on round-up:
  - Stimulus: mag_i=0x7FFFF.
  - Required: e=135, f=0x00, inexact=1.
- Tie to even:
  - Stimulus: 0x40400.
  - Required: e=134, f=0x00, inexact=1.
  - Stimulus: 0x40C00.
  - Required: e=134, f=0x02.
- Specials, one per beat:
  - isZ → s=1/e=0xFF/f=0, divByZero=1.
  - s_op_i=1 with mag 0x100 → e=0xFF/f=0x40, invalid=1.
  - isSNAN → qNaN, invalid=1.
  - isInf → +Inf.
  - mag_i=0 → all-zero result.
- Backpressure and reset:
  - Stimulus: 5 back-to-back beats; ready_i low for 4 cycles once the first reaches the output.
  - Required: ready_o low during the stall, outputs stable, all 5 results delivered in order with no loss or duplication.
  - Then assert rst=0 for 1 cycle with beats in flight.
  - Required: valid_o=0 and all outputs 0 on the next cycle, ready_o=1, no stale result emitted.
